// File: rtl/dmem_responder.sv
// Doubleword data memory behind valid/ready request and response channels,
// with a fixed number of wait states between request acceptance and the access.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [63:0] mem_q [DEPTH];

    logic          accept;
    logic          acc_fire;
    logic          acc_write;
    logic [63:0]   acc_addr;
    logic [63:0]   acc_wdata;
    logic [7:0]    acc_wstrb;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic [63:0]   cur_word;
    logic [63:0]   merged_word;

    assign accept = req_valid && (state_q == S_IDLE);

    // With zero wait states the access happens on the accept edge, so it must
    // use the live request rather than the (not yet loaded) latched copy.
    assign acc_write = (state_q == S_IDLE) ? req_write : write_q;
    assign acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign acc_wstrb = (state_q == S_IDLE) ? req_wstrb : wstrb_q;

    assign acc_fire = ((state_q == S_IDLE) && accept && (LATENCY == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q == 4'd0));

    assign acc_err  = (|acc_addr[2:0]) || (|acc_addr[63:3+AW]);
    assign acc_idx  = acc_addr[3+AW-1:3];
    assign cur_word = mem_q[acc_idx];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_merge
            assign merged_word[8*gi +: 8] = acc_wstrb[gi] ? acc_wdata[8*gi +: 8]
                                                          : cur_word[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (acc_fire) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_write) ? 64'd0 : cur_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
        end
    end

    // Storage clears on reset, so it lives in flops rather than block RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (acc_fire && acc_write && !acc_err) begin
            mem_q[acc_idx] <= merged_word;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a LATENCY=2 instance for the functional checks and a
// LATENCY=0 instance for back-to-back throughput.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [63:0] rsp_rdata;

    logic        b_reset;
    logic        b_req_valid, b_req_ready, b_req_write;
    logic [63:0] b_req_addr, b_req_wdata;
    logic [7:0]  b_req_wstrb;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
    logic [63:0] b_rsp_rdata;

    int vectors = 0;
    int miscompares = 0;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
        .clk(clk), .reset(b_reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full request/response on the LATENCY=2 instance with rsp_ready held high.
    task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] s, output logic [63:0] rd, output logic re,
                       output int lat);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        rsp_ready = 1'b1;
        check("accept_ready", 64'(req_ready), 64'd1);
        tick;
        req_valid = 1'b0; req_addr = 64'hFFFF_FFFF_FFFF_FFF8; req_wdata = '1; req_write = 1'b1;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            check("wait_ready_low", 64'(req_ready), 64'd0);
            tick;
            lat++;
        end
        check("rsp_valid_seen", 64'(rsp_valid), 64'd1);
        check("rsp_ready_low", 64'(req_ready), 64'd0);
        check("rsp_busy", 64'(busy), 64'd1);
        rd = rsp_rdata;
        re = rsp_err;
        $display("txn w=%0d addr=%h wdata=%h wstrb=%h -> rdata=%h err=%0d lat=%0d",
                 w, a, d, s, rd, re, lat);
        tick;
        check("rsp_cleared_valid", 64'(rsp_valid), 64'd0);
        check("rsp_cleared_rdata", rsp_rdata, 64'd0);
        check("idle_ready", 64'(req_ready), 64'd1);
    endtask

    logic [63:0] rd;
    logic        re;
    int          lat;
    int          n;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; b_reset = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
        b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_req_wstrb = 0;
        b_rsp_ready = 0;
        tick; tick;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rdata", rsp_rdata, 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        reset = 1'b0; b_reset = 1'b0;
        tick;

        txn(1'b0, 64'h0, 64'h0, 8'h00, rd, re, lat);
        check("ld0_lat", 64'(lat), 64'd3);
        check("ld0_rdata", rd, 64'd0);
        check("ld0_err", 64'(re), 64'd0);

        txn(1'b1, 64'h10, 64'h1122334455667788, 8'hFF, rd, re, lat);
        check("st10_rdata", rd, 64'd0);
        check("st10_err", 64'(re), 64'd0);
        txn(1'b0, 64'h10, 64'h0, 8'h00, rd, re, lat);
        check("ld10_full", rd, 64'h1122334455667788);

        txn(1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, rd, re, lat);
        txn(1'b0, 64'h10, 64'h0, 8'h00, rd, re, lat);
        check("ld10_partial", rd, 64'h11223344AAAAAAAA);

        txn(1'b1, 64'h10, 64'h0, 8'h00, rd, re, lat);
        check("st_nostrb_err", 64'(re), 64'd0);
        txn(1'b0, 64'h10, 64'h0, 8'h00, rd, re, lat);
        check("ld10_nostrb", rd, 64'h11223344AAAAAAAA);

        txn(1'b0, 64'h13, 64'h0, 8'h00, rd, re, lat);
        check("misalign_err", 64'(re), 64'd1);
        check("misalign_rdata", rd, 64'd0);
        txn(1'b0, 64'h800, 64'h0, 8'h00, rd, re, lat);
        check("oor_err", 64'(re), 64'd1);
        check("oor_rdata", rd, 64'd0);
        txn(1'b1, 64'h800, 64'hFFFFFFFFFFFFFFFF, 8'hFF, rd, re, lat);
        check("oor_st_err", 64'(re), 64'd1);
        txn(1'b0, 64'h0, 64'h0, 8'h00, rd, re, lat);
        check("oor_st_word0", rd, 64'd0);
        txn(1'b0, 64'h10, 64'h0, 8'h00, rd, re, lat);
        check("oor_st_word2", rd, 64'h11223344AAAAAAAA);

        // Backpressure: response held for 5 cycles, stray request ignored.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; rsp_ready = 1'b0;
        tick;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin tick; n++; end
        check("bp_valid", 64'(rsp_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h18;
                req_wdata = 64'h5555555555555555; req_wstrb = 8'hFF;
            end
            if (k == 2) req_valid = 1'b0;
            tick;
            check("bp_hold_valid", 64'(rsp_valid), 64'd1);
            check("bp_hold_rdata", rsp_rdata, 64'h11223344AAAAAAAA);
            check("bp_hold_err", 64'(rsp_err), 64'd0);
            check("bp_hold_ready", 64'(req_ready), 64'd0);
        end
        $display("backpressure held 5 cycles rdata=%h", rsp_rdata);
        rsp_ready = 1'b1;
        tick;
        check("bp_release", 64'(rsp_valid), 64'd0);
        txn(1'b0, 64'h18, 64'h0, 8'h00, rd, re, lat);
        check("bp_stray_ignored", rd, 64'd0);

        // LATENCY=0 instance: store, then back-to-back loads with valid/ready held high.
        b_rsp_ready = 1'b1;
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 64'h8;
        b_req_wdata = 64'hDEADBEEFCAFEF00D; b_req_wstrb = 8'hFF;
        check("b_idle_ready", 64'(b_req_ready), 64'd1);
        tick;
        check("b_st_valid", 64'(b_rsp_valid), 64'd1);
        check("b_st_ready", 64'(b_req_ready), 64'd0);
        check("b_st_err", 64'(b_rsp_err), 64'd0);
        b_req_write = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick;
            check("b_bubble_ready", 64'(b_req_ready), 64'd1);
            check("b_bubble_valid", 64'(b_rsp_valid), 64'd0);
            check("b_bubble_busy", 64'(b_busy), 64'd0);
            tick;
            check("b_ld_valid", 64'(b_rsp_valid), 64'd1);
            check("b_ld_rdata", b_rsp_rdata, 64'hDEADBEEFCAFEF00D);
            $display("lat0 load %0d rdata=%h", k, b_rsp_rdata);
        end
        b_req_valid = 1'b0;
        tick;

        // Reset during WAIT of a store abandons it.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20;
        req_wdata = 64'h0123456789ABCDEF; req_wstrb = 8'hFF; rsp_ready = 1'b1;
        tick;
        req_valid = 1'b0;
        check("mid_busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ready", 64'(req_ready), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_err", 64'(rsp_err), 64'd0);
        tick; tick;
        reset = 1'b0;
        tick;
        txn(1'b0, 64'h20, 64'h0, 8'h00, rd, re, lat);
        check("mid_rst_ld20", rd, 64'd0);
        txn(1'b0, 64'h10, 64'h0, 8'h00, rd, re, lat);
        check("mid_rst_ld10", rd, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
